// File: rtl/of_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | of_pkg                                                                  |
// | Shared constants and the operand packet type for the operand fetch      |
// | stage and its scoreboard.                                               |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
package of_pkg;

  // Data width; matches the register bank word.
  localparam int DW   = 32;
  // Register address width.
  localparam int AW   = 5;
  // Number of architectural registers.
  localparam int NREG = 2 ** AW;
  // Opcode passthrough width.
  localparam int OPW  = 8;

  // Operand-complete packet handed to the execute stage.
  typedef struct packed {
    logic [DW-1:0]  a;
    logic [DW-1:0]  b;
    logic [AW-1:0]  dr;
    logic           wen;
    logic [OPW-1:0] op;
  } operand_pkt_t;

endpackage : of_pkg
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | reg_scoreboard                                                          |
// | One busy bit per register, marking registers that have an in-flight     |
// | writer. A set and a clear of the same register in one cycle leaves the  |
// | bit set: the set belongs to a newer writer than the one retiring.       |
// |                                                                         |
// | Ports:                                                                  |
// |   clk, reset            clock, asynchronous active-high reset           |
// |   set_en, set_addr      mark a register busy                            |
// |   clr_en, clr_addr      mark a register free                            |
// |   rd_addr1/2/3          read addresses (sr1, sr2, dr)                   |
// |   busy1/2/3             busy bit at each read address                   |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module reg_scoreboard
  import of_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          set_en,
  input  logic [AW-1:0] set_addr,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_addr,
  input  logic [AW-1:0] rd_addr1,
  input  logic [AW-1:0] rd_addr2,
  input  logic [AW-1:0] rd_addr3,
  output logic          busy1,
  output logic          busy2,
  output logic          busy3
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    // Clear first so a same-cycle set of the same register overrides it.
    if (clr_en) busy_d[clr_addr] = 1'b0;
    if (set_en) busy_d[set_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign busy1 = busy_q[rd_addr1];
  assign busy2 = busy_q[rd_addr2];
  assign busy3 = busy_q[rd_addr3];

endmodule : reg_scoreboard
`default_nettype wire

// File: rtl/operand_fetch_stage.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | operand_fetch_stage                                                     |
// | Pipeline stage in front of the 32x32 register bank. Holds one decoded   |
// | instruction, reads its sources from the bank (bypassing a same-cycle    |
// | writeback), stalls on RAW/WAW hazards against in-flight writers and     |
// | hands an operand-complete packet to execute.                            |
// |                                                                         |
// | Ports:                                                                  |
// |   clk, reset                 clock, asynchronous active-high reset      |
// |   in_valid/in_ready          upstream handshake                         |
// |   in_sr1/sr2/dr/wen/op       decoded instruction                        |
// |   sr1, sr2                   bank read addresses                        |
// |   rdData1, rdData2           bank read data (combinational)             |
// |   wb_write/wb_dr/wb_data     writeback commit (same as bank write)      |
// |   out_valid/out_ready        downstream handshake                       |
// |   out_a/b/dr/wen/op          operand packet                             |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module operand_fetch_stage
  import of_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [AW-1:0]  in_sr1,
  input  logic [AW-1:0]  in_sr2,
  input  logic [AW-1:0]  in_dr,
  input  logic           in_wen,
  input  logic [OPW-1:0] in_op,
  output logic [AW-1:0]  sr1,
  output logic [AW-1:0]  sr2,
  input  logic [DW-1:0]  rdData1,
  input  logic [DW-1:0]  rdData2,
  input  logic           wb_write,
  input  logic [AW-1:0]  wb_dr,
  input  logic [DW-1:0]  wb_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [DW-1:0]  out_a,
  output logic [DW-1:0]  out_b,
  output logic [AW-1:0]  out_dr,
  output logic           out_wen,
  output logic [OPW-1:0] out_op
);

  // Hold register S
  logic           s_valid_q, s_valid_d;
  logic [AW-1:0]  s_sr1_q,   s_sr1_d;
  logic [AW-1:0]  s_sr2_q,   s_sr2_d;
  logic [AW-1:0]  s_dr_q,    s_dr_d;
  logic           s_wen_q,   s_wen_d;
  logic [OPW-1:0] s_op_q,    s_op_d;

  // Output register
  logic           out_valid_q, out_valid_d;
  operand_pkt_t   out_pkt_q,   out_pkt_d;

  // Hazard and handshake terms
  logic wb_hit1, wb_hit2, wb_hit_dr;
  logic busy1, busy2, busy_dr;
  logic stall, move, accept;
  logic [DW-1:0] opnd_a, opnd_b;

  reg_scoreboard u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .set_en   (move && s_wen_q),
    .set_addr (s_dr_q),
    .clr_en   (wb_write),
    .clr_addr (wb_dr),
    .rd_addr1 (s_sr1_q),
    .rd_addr2 (s_sr2_q),
    .rd_addr3 (s_dr_q),
    .busy1    (busy1),
    .busy2    (busy2),
    .busy3    (busy_dr)
  );

  // The bank only updates at the edge, so a writeback landing this cycle
  // must be forwarded and also resolves any hazard on that register.
  always_comb begin
    wb_hit1   = wb_write && (wb_dr == s_sr1_q);
    wb_hit2   = wb_write && (wb_dr == s_sr2_q);
    wb_hit_dr = wb_write && (wb_dr == s_dr_q);

    opnd_a = wb_hit1 ? wb_data : rdData1;
    opnd_b = wb_hit2 ? wb_data : rdData2;

    stall  = s_valid_q && ((busy1 && !wb_hit1) ||
                           (busy2 && !wb_hit2) ||
                           (s_wen_q && busy_dr && !wb_hit_dr));
    move   = s_valid_q && !stall && (!out_valid_q || out_ready);
    in_ready = !s_valid_q || move;
    accept = in_valid && in_ready;
  end

  // Next state for S: a new accept replaces a departing instruction in the
  // same cycle, giving one instruction per cycle.
  always_comb begin
    s_valid_d = s_valid_q;
    s_sr1_d   = s_sr1_q;
    s_sr2_d   = s_sr2_q;
    s_dr_d    = s_dr_q;
    s_wen_d   = s_wen_q;
    s_op_d    = s_op_q;
    if (accept) begin
      s_valid_d = 1'b1;
      s_sr1_d   = in_sr1;
      s_sr2_d   = in_sr2;
      s_dr_d    = in_dr;
      s_wen_d   = in_wen;
      s_op_d    = in_op;
    end else if (move) begin
      s_valid_d = 1'b0;
    end
  end

  // Next state for the output register; payload holds while not moving.
  always_comb begin
    out_valid_d = out_valid_q;
    out_pkt_d   = out_pkt_q;
    if (move) begin
      out_valid_d   = 1'b1;
      out_pkt_d.a   = opnd_a;
      out_pkt_d.b   = opnd_b;
      out_pkt_d.dr  = s_dr_q;
      out_pkt_d.wen = s_wen_q;
      out_pkt_d.op  = s_op_q;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_valid_q   <= 1'b0;
      s_sr1_q     <= '0;
      s_sr2_q     <= '0;
      s_dr_q      <= '0;
      s_wen_q     <= 1'b0;
      s_op_q      <= '0;
      out_valid_q <= 1'b0;
      out_pkt_q   <= '0;
    end else begin
      s_valid_q   <= s_valid_d;
      s_sr1_q     <= s_sr1_d;
      s_sr2_q     <= s_sr2_d;
      s_dr_q      <= s_dr_d;
      s_wen_q     <= s_wen_d;
      s_op_q      <= s_op_d;
      out_valid_q <= out_valid_d;
      out_pkt_q   <= out_pkt_d;
    end
  end

  // Read addresses are forced to 0 when S is empty.
  assign sr1 = s_valid_q ? s_sr1_q : '0;
  assign sr2 = s_valid_q ? s_sr2_q : '0;

  assign out_valid = out_valid_q;
  assign out_a     = out_pkt_q.a;
  assign out_b     = out_pkt_q.b;
  assign out_dr    = out_pkt_q.dr;
  assign out_wen   = out_pkt_q.wen;
  assign out_op    = out_pkt_q.op;

endmodule : operand_fetch_stage
`default_nettype wire

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- Pipeline stage directly upstream of the 32x32 register bank.
- Accepts decoded instructions (sr1, sr2, dr, write-enable, opcode) over a valid/ready handshake.
- Drives the bank's read addresses and bypasses same-cycle writeback data.
- Tracks in-flight destination registers in a scoreboard, stalls on RAW/WAW hazards, and emits an operand-complete packet to the execute stage.

Parameters:
- DW, 32, data width; matches the register bank word.
- AW, 5, register address width; NREG = 2**AW = 32.
- OPW, 8, opcode passthrough width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept an instruction.
- in_sr1  in  AW  source register 1.
- in_sr2  in  AW  source register 2.
- in_dr  in  AW  destination register.
- in_wen  in  1  instruction will write in_dr.
- in_op  in  OPW  opcode, passed through.
- sr1  out  AW  register bank read address 1.
- sr2  out  AW  register bank read address 2.
- rdData1  in  DW  register bank read data 1; combinational from sr1.
- rdData2  in  DW  register bank read data 2; combinational from sr2.
- wb_write  in  1  writeback commit this cycle; same signal as the bank's write.
- wb_dr  in  AW  writeback destination.
- wb_data  in  DW  writeback data.
- out_valid  out  1  operand packet valid.
- out_ready  in  1  execute stage accepts packet.
- out_a  out  DW  operand 1.
- out_b  out  DW  operand 2.
- out_dr  out  AW  destination register.
- out_wen  out  1  destination write flag.
- out_op  out  OPW  opcode.

Behaviour:
- Reset (async, active-high): s_valid=0, out_valid=0, out_a/out_b/out_dr/out_op=0, out_wen=0, scoreboard busy[NREG-1:0]=0. in_ready=1 as soon as reset deasserts. In-flight instructions are discarded.
- Hold register S: captures in_sr1/in_sr2/in_dr/in_wen/in_op on in_valid&in_ready. sr1/sr2 are driven from S fields at all times (0 when S is empty).
- Operand select, per source x:
  - If wb_write && wb_dr==S.srx, use wb_data (bypass; the bank updates only at the clock edge).
  - Otherwise use rdDatax.
- Hazards:
  - src_hazard_x = busy[S.srx] && !(wb_write && wb_dr==S.srx).
  - waw_hazard = S.wen && busy[S.dr] && !(wb_write && wb_dr==S.dr).
  - stall = s_valid && (src_hazard_1 || src_hazard_2 || waw_hazard).
- Transfer: move = s_valid && !stall && (!out_valid || out_ready). On move:
  - Output register loads the selected operands and S.dr/S.wen/S.op.
  - out_valid=1.
- in_ready = !s_valid || move. A simultaneous accept and move is allowed, giving full throughput of 1 instruction/cycle.
- out_valid clears when out_ready is high and there is no move in the same cycle. Output is stable while out_valid && !out_ready.
- Latency: instruction accepted at edge N appears as out_valid after edge N+1, provided there are no hazards and no backpressure.
- Scoreboard:
  - On move with S.wen: set busy[S.dr].
  - On wb_write: clear busy[wb_dr].
  - Same register set and cleared in one cycle: set wins (new writer pending).
  - WAW stall guarantees at most one pending writer per register.
- Register 0 is an ordinary register (the bank has no hardwired zero).
- A wb_write to a non-busy register is legal: the clear is a no-op and the bypass still applies.
- sr1==sr2 is legal; both operands get the same value.

Decomposition:
- Shared package of_pkg: DW, AW, NREG, OPW constants; operand packet struct (a, b, dr, wen, op).
- One natural sub-module, reg_scoreboard: NREG busy bits with set port (en, addr) and clear port (en, addr), set-wins priority. Three read ports: busy[sr1], busy[sr2], busy[dr].

Test Plan:
- Reset mid-stream: busy[3]=1, out_valid=1, then assert reset -> outputs 0 and busy=0 immediately without a clock edge; after release, in_ready=1.
- No hazard: bank r1=0x11, r2=0x22; issue sr1=1, sr2=2, dr=5, wen=1 -> out_a=0x11, out_b=0x22, out_dr=5 one cycle after accept; busy[5]=1.
- RAW stall then bypass: issue dr=5 writer, then sr1=5 reader -> reader stalls (in_ready=0). Assert wb_write, wb_dr=5, wb_data=0xDEAD -> reader moves that cycle with out_a=0xDEAD; busy[5]=0.
- WAW stall: two back-to-back writers with dr=7 -> second holds until wb_dr=7; busy[7] remains 1 afterwards (set wins).
- Backpressure: out_ready=0 for 4 cycles with 3 instructions offered -> out packet stable, S holds one, in_ready=0. Release -> all 3 delivered in order, none lost or duplicated.
- Throughput: 8 independent instructions (wen=0) with out_ready=1 -> 8 consecutive out_valid cycles.
